// File: rtl/iir_cascade_ctrl.sv
// iir_cascade_ctrl: biquad cascade (direct form I) time-multiplexed over one shared 24x18 MAC,
// with double-buffered coefficients and lrclk-framed sample start/commit.
module iir_cascade_ctrl #(
   parameter int MAX_STAGES = 4
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               lrclk_negedge,
   input  logic               lrclk_posedge,
   input  logic               i_valid,
   input  logic signed [15:0] x_in,
   input  logic [2:0]         num_stages,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_stage,
   input  logic [2:0]         cfg_sel,
   input  logic signed [17:0] cfg_data,
   output logic signed [15:0] audio_out,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overrun
);
   localparam int SW = (MAX_STAGES > 1) ? $clog2(MAX_STAGES) : 1;
   localparam logic [2:0] MAXS = 3'(MAX_STAGES);
   typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
   state_t                    state_q;
   logic [4:0][17:0]          pend_q [MAX_STAGES];
   logic [4:0][17:0]          act_q  [MAX_STAGES];
   logic [4:0][17:0]          pend_d [MAX_STAGES];
   logic signed [23:0]        x1_q [MAX_STAGES];
   logic signed [23:0]        x2_q [MAX_STAGES];
   logic signed [23:0]        y1_q [MAX_STAGES];
   logic signed [23:0]        y2_q [MAX_STAGES];
   logic signed [23:0]        xs_q;
   logic signed [47:0]        acc_q;
   logic [SW-1:0]             stage_q;
   logic [2:0]                term_q;
   logic [2:0]                nst_q;
   logic signed [15:0]        result_q;
   logic signed [15:0]        audio_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      ovr_q;
   logic signed [23:0]        mul_a;
   logic signed [17:0]        mul_b;
   logic signed [41:0]        prod;
   logic signed [47:0]        acc_d;
   logic signed [47:0]        rnd_d;
   logic signed [47:0]        ysh_d;
   logic signed [23:0]        y_d;
   logic signed [23:0]        yq_d;
   logic signed [15:0]        res_d;
   logic                      start;
   logic                      last;

   // Writes land in the pending bank; the start edge copies pend_d so a coincident write is included.
   always_comb begin
      pend_d = pend_q;
      if (cfg_we && {1'b0, cfg_stage} < MAXS && cfg_sel <= 3'd4)
         pend_d[cfg_stage][cfg_sel] = cfg_data;
   end

   assign mul_a = term_q == 3'd0 ? xs_q :
                  term_q == 3'd1 ? x1_q[stage_q] :
                  term_q == 3'd2 ? x2_q[stage_q] :
                  term_q == 3'd3 ? y1_q[stage_q] : y2_q[stage_q];
   assign mul_b = act_q[stage_q][term_q];
   assign prod  = mul_a * mul_b;
   assign acc_d = (term_q == 3'd0 ? 48'sd0 : acc_q) + $signed({{6{prod[41]}}, prod});
   assign rnd_d = acc_q + 48'sd32768;
   assign ysh_d = rnd_d >>> 16;
   assign y_d   = ysh_d > 48'sd8388607 ? 24'sh7fffff : ysh_d < -48'sd8388608 ? 24'sh800000 : ysh_d[23:0];
   assign yq_d  = y_d >>> 3;
   assign res_d = yq_d > 24'sd32767 ? 16'sh7fff : yq_d < -24'sd32768 ? 16'sh8000 : yq_d[15:0];
   assign start = lrclk_negedge && i_valid && state_q == IDLE;
   assign last  = 3'(stage_q) == nst_q - 3'd1;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         pend_q   <= '{default: '0};
         act_q    <= '{default: '0};
         x1_q     <= '{default: '0};
         x2_q     <= '{default: '0};
         y1_q     <= '{default: '0};
         y2_q     <= '{default: '0};
         xs_q     <= '0;
         acc_q    <= '0;
         stage_q  <= '0;
         term_q   <= '0;
         nst_q    <= '0;
         result_q <= '0;
         audio_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         pend_q <= pend_d;
         done_q <= 1'b0;
         ovr_q  <= lrclk_negedge && busy_q;
         if (lrclk_posedge) audio_q <= result_q;
         unique case (state_q)
            IDLE: if (start) begin
               act_q   <= pend_d;
               xs_q    <= {{5{x_in[15]}}, x_in, 3'b000};
               nst_q   <= num_stages > MAXS ? MAXS : num_stages;
               stage_q <= '0;
               term_q  <= '0;
               if (num_stages == 3'd0) begin
                  state_q  <= DONE;
                  result_q <= x_in;
                  done_q   <= 1'b1;
               end else begin
                  state_q <= MAC;
                  busy_q  <= 1'b1;
               end
            end
            MAC: begin
               acc_q  <= acc_d;
               term_q <= term_q == 3'd4 ? 3'd0 : term_q + 3'd1;
               if (term_q == 3'd4) state_q <= WB;
            end
            WB: begin
               x2_q[stage_q] <= x1_q[stage_q];
               x1_q[stage_q] <= xs_q;
               y2_q[stage_q] <= y1_q[stage_q];
               y1_q[stage_q] <= y_d;
               xs_q          <= y_d;
               if (last) begin
                  state_q  <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= res_d;
               end else begin
                  state_q <= MAC;
                  stage_q <= stage_q + 1'b1;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign audio_out = audio_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_overrun = ovr_q;
endmodule

// File: tb/tb_iir_cascade_ctrl.sv
// tb_iir_cascade_ctrl: table vectors, hand-written corner sequences and random samples
// checked against an arithmetic model of the biquad cascade.
module tb_iir_cascade_ctrl;
   localparam int MAXS = 4;
   logic               clk = 1'b0;
   logic               i_rst_n = 1'b1;
   logic               lrclk_negedge = 1'b0;
   logic               lrclk_posedge = 1'b0;
   logic               i_valid = 1'b0;
   logic signed [15:0] x_in = '0;
   logic [2:0]         num_stages = '0;
   logic               cfg_we = 1'b0;
   logic [1:0]         cfg_stage = '0;
   logic [2:0]         cfg_sel = '0;
   logic signed [17:0] cfg_data = '0;
   logic signed [15:0] audio_out;
   logic               o_busy;
   logic               o_done;
   logic               o_overrun;
   int                 checks = 0;
   int                 errors = 0;
   longint             pend_m [MAXS][5];
   longint             act_m  [MAXS][5];
   longint             hx1 [MAXS];
   longint             hx2 [MAXS];
   longint             hy1 [MAXS];
   longint             hy2 [MAXS];
   longint             last_out = 0;

   typedef struct {
      longint b1;
      int     x;
      longint res;
   } vec_t;
   vec_t tbl [10];

   iir_cascade_ctrl #(.MAX_STAGES(MAXS)) dut (
      .clk(clk), .i_rst_n(i_rst_n), .lrclk_negedge(lrclk_negedge), .lrclk_posedge(lrclk_posedge),
      .i_valid(i_valid), .x_in(x_in), .num_stages(num_stages), .cfg_we(cfg_we), .cfg_stage(cfg_stage),
      .cfg_sel(cfg_sel), .cfg_data(cfg_data), .audio_out(audio_out), .o_busy(o_busy), .o_done(o_done),
      .o_overrun(o_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint sat(input longint v, input longint lo, input longint hi);
      return v > hi ? hi : v < lo ? lo : v;
   endfunction

   // One sample through the cascade: Q2.16 products summed, rounded, saturated, stage to stage.
   function automatic longint model_sample(input longint x, input int n);
      longint s, acc, y;
      int ns;
      ns = n > MAXS ? MAXS : n;
      if (ns == 0) return x;
      act_m = pend_m;
      s = x * 8;
      for (int k = 0; k < ns; k++) begin
         acc = act_m[k][0] * s + act_m[k][1] * hx1[k] + act_m[k][2] * hx2[k]
             + act_m[k][3] * hy1[k] + act_m[k][4] * hy2[k];
         y = sat((acc + 32768) >>> 16, -8388608, 8388607);
         hx2[k] = hx1[k]; hx1[k] = s; hy2[k] = hy1[k]; hy1[k] = y;
         s = y;
      end
      return sat(s >>> 3, -32768, 32767);
   endfunction

   function automatic void model_reset();
      foreach (pend_m[i, j]) pend_m[i][j] = 0;
      foreach (hx1[i]) begin hx1[i] = 0; hx2[i] = 0; hy1[i] = 0; hy2[i] = 0; end
      last_out = 0;
   endfunction

   task automatic cfg_write(input int st, input int sel, input longint d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_stage = 2'(st); cfg_sel = 3'(sel); cfg_data = 18'(d);
      @(negedge clk);
      cfg_we = 1'b0;
      if (st < MAXS && sel <= 4) pend_m[st][sel] = d;
   endtask

   task automatic prog(input int st, input longint b1, input longint b2, input longint b3,
                       input longint a2, input longint a3);
      cfg_write(st, 0, b1); cfg_write(st, 1, b2); cfg_write(st, 2, b3);
      cfg_write(st, 3, a2); cfg_write(st, 4, a3);
   endtask

   task automatic start_pulse(input logic signed [15:0] x, input logic [2:0] n);
      @(negedge clk);
      x_in = x; num_stages = n; i_valid = 1'b1; lrclk_negedge = 1'b1;
      @(negedge clk);
      lrclk_negedge = 1'b0; x_in = 16'($urandom); num_stages = 3'($urandom); i_valid = 1'($urandom);
   endtask

   // lat0 = negedges already spent since the one right after the start edge.
   task automatic finish_sample(input int lat0, input int ns, input longint exp, input int dly, input string tag);
      int lat;
      lat = lat0;
      while (!o_done && lat < 6 * MAXS + 8) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, 6 * ns);
      check({tag, "_busy_at_done"}, o_busy, 0);
      repeat (dly) begin
         @(negedge clk);
         check({tag, "_hold"}, audio_out, last_out);
      end
      lrclk_posedge = 1'b1;
      @(negedge clk);
      lrclk_posedge = 1'b0;
      check({tag, "_audio"}, audio_out, exp);
      last_out = exp;
   endtask

   task automatic run_sample(input logic signed [15:0] x, input logic [2:0] n, input longint exp,
                             input int dly, input string tag);
      int ns;
      ns = int'(n) > MAXS ? MAXS : int'(n);
      start_pulse(x, n);
      if (ns > 0) check({tag, "_busy"}, o_busy, 1);
      finish_sample(0, ns, exp, dly, tag);
   endtask

   initial begin
      longint exp;
      int lat;
      int seen;
      int nw;
      logic signed [15:0] rx;
      logic [2:0] rn;
      tbl[0] = '{65536, 1000, 1000};
      tbl[1] = '{131071, 30000, 32767};
      tbl[2] = '{131071, -30000, -32768};
      tbl[3] = '{32768, 1000, 500};
      tbl[4] = '{-65536, 1234, -1234};
      tbl[5] = '{65536, -32768, -32768};
      tbl[6] = '{0, 5000, 0};
      tbl[7] = '{8192, 800, 100};
      tbl[8] = '{-131072, 20000, -32768};
      tbl[9] = '{98304, -2000, -3000};
      model_reset();

      #3 i_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_audio", audio_out, 0);
      check("reset_busy", o_busy, 0);
      check("reset_done", o_done, 0);
      check("reset_overrun", o_overrun, 0);
      i_rst_n = 1'b1;

      run_sample(16'sd1234, 3'd0, 1234, 0, "bypass");

      @(negedge clk);
      i_valid = 1'b0; num_stages = 3'd1; lrclk_negedge = 1'b1;
      @(negedge clk);
      lrclk_negedge = 1'b0;
      seen = 0;
      repeat (10) begin @(negedge clk); if (o_busy || o_done) seen = 1; end
      check("novalid_no_start", seen, 0);

      for (int i = 0; i < 10; i++) begin
         prog(0, tbl[i].b1, 0, 0, 0, 0);
         void'(model_sample(tbl[i].x, 1));
         run_sample(16'(tbl[i].x), 3'd1, tbl[i].res, i % 3, $sformatf("tbl%0d", i));
      end

      prog(0, 65536, 0, 0, 0, 0);
      exp = model_sample(1000, 1);
      start_pulse(16'sd1000, 3'd1);
      cfg_write(0, 0, 0);
      finish_sample(2, 1, exp, 0, "shadow_cur");
      exp = model_sample(1000, 1);
      run_sample(16'sd1000, 3'd1, exp, 0, "shadow_next");
      check("shadow_next_zero", audio_out, 0);

      @(negedge clk);
      x_in = 16'sd1000; num_stages = 3'd1; i_valid = 1'b1; lrclk_negedge = 1'b1;
      cfg_we = 1'b1; cfg_stage = 2'd0; cfg_sel = 3'd0; cfg_data = 18'sd65536;
      pend_m[0][0] = 65536;
      exp = model_sample(1000, 1);
      @(negedge clk);
      lrclk_negedge = 1'b0; cfg_we = 1'b0;
      finish_sample(0, 1, exp, 1, "coincident_write");
      cfg_write(0, 5, 12345);
      cfg_write(0, 7, -1);
      exp = model_sample(-700, 1);
      run_sample(-16'sd700, 3'd1, exp, 0, "bad_sel_ignored");

      prog(0, 65536, 65536, 0, 0, 0);
      for (int k = 1; k < MAXS; k++) prog(k, 65536, 0, 0, 0, 0);
      exp = model_sample(100, 4);
      start_pulse(16'sd100, 3'd4);
      lat = 0;
      repeat (9) begin @(negedge clk); lat++; end
      i_valid = 1'b1; x_in = 16'sd5000; lrclk_negedge = 1'b1;
      @(negedge clk); lat++;
      lrclk_negedge = 1'b0;
      check("overrun_pulse", o_overrun, 1);
      check("overrun_still_busy", o_busy, 1);
      @(negedge clk); lat++;
      check("overrun_one_cycle", o_overrun, 0);
      finish_sample(lat, 4, exp, 0, "overrun");
      exp = model_sample(7, 4);
      run_sample(16'sd7, 3'd4, exp, 0, "overrun_next");
      run_sample(16'sd900, 3'd7, model_sample(900, 7), 0, "clamp");

      start_pulse(16'sd2000, 3'd4);
      repeat (3) @(negedge clk);
      #2 i_rst_n = 1'b0;
      #1;
      check("midrst_audio", audio_out, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_done", o_done, 0);
      check("midrst_overrun", o_overrun, 0);
      @(negedge clk);
      i_rst_n = 1'b1;
      model_reset();
      seen = 0;
      repeat (30) begin @(negedge clk); if (o_done || o_busy) seen = 1; end
      check("midrst_no_done", seen, 0);

      prog(0, 67, 0, -67, 130709, -65400);
      void'(model_sample(1000, 1));
      run_sample(16'sd1000, 3'd1, 1, 0, "bp_first");
      for (int i = 1; i < 3200; i++) begin
         exp = model_sample(0, 1);
         run_sample(16'sd0, 3'd1, exp, 0, "bp");
      end

      for (int s = 0; s < 300; s++) begin
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++)
            cfg_write($urandom_range(0, 3), $urandom_range(0, 7), longint'($urandom_range(0, 131071)) - 65536);
         rx = 16'($urandom);
         rn = 3'($urandom);
         exp = model_sample(rx, int'(rn));
         run_sample(rx, rn, exp, $urandom_range(0, 2), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/iir_cascade_ctrl.md
IIR_CASCADE_CTRL -- requirements
Module: iir_cascade_ctrl

Interface
REQ-001 SHALL have parameter MAX_STAGES, default 4, maximum biquad stages sequenced per sample.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port lrclk_negedge, input, 1, one-cycle pulse marking sample start.
REQ-005 SHALL have port lrclk_posedge, input, 1, one-cycle pulse marking output commit.
REQ-006 SHALL have port i_valid, input, 1, sample starts permitted only while high.
REQ-007 SHALL have port x_in, input, 16, signed audio sample.
REQ-008 SHALL have port num_stages, input, 3, active stage count; 0 means bypass; values above MAX_STAGES clamp to MAX_STAGES.
REQ-009 SHALL have port cfg_we, input, 1, coefficient write strobe.
REQ-010 SHALL have port cfg_stage, input, 2, stage index of the write.
REQ-011 SHALL have port cfg_sel, input, 3, coefficient select: 0=b1, 1=b2, 2=b3, 3=a2, 4=a3; 5-7 ignored.
REQ-012 SHALL have port cfg_data, input, 18, signed Q2.16 coefficient (65536 = 1.0).
REQ-013 SHALL have port audio_out, output, 16, signed filtered sample.
REQ-014 SHALL have port o_busy, output, 1, high while a computation is in progress.
REQ-015 SHALL have port o_done, output, 1, one-cycle pulse when a result is ready.
REQ-016 SHALL have port o_overrun, output, 1, one-cycle pulse when a sample start is dropped.

Function
REQ-017 SHALL use a single shared 24x18 signed multiplier and a 48-bit accumulator for all stages (direct form I).
REQ-018 State machine SHALL have states IDLE, MAC, WB and DONE.
REQ-019 IDLE->MAC SHALL occur on lrclk_negedge while i_valid=1 and not busy.
REQ-020 On that transition the block SHALL latch x_in, sign-extend it to 24 bits and shift left by 3 as the stage-0 input, and copy the pending coefficient bank to the active bank.
REQ-021 MAC SHALL take 5 cycles per stage with accumulator cleared at term 0.
- Terms in order: b1*x, b2*x1, b3*x2, a2*y1, a3*y2, using that stage's history.
REQ-022 WB SHALL take 1 cycle per stage.
- y = (acc + 32768) >>> 16, saturated to the signed 24-bit range.
- Stage history shifts: x2<=x1, x1<=x, y2<=y1, y1<=y.
- y becomes the next stage's input.
- WB->MAC for the next stage; WB->DONE after the last stage.
REQ-023 Latency SHALL be 6*N cycles from the start pulse to DONE, for N active stages.
REQ-024 DONE SHALL last 1 cycle, pulse o_done, store result = sat16(y >>> 3), then return to IDLE.
REQ-025 With num_stages=0, result SHALL equal x_in and o_done SHALL pulse 1 cycle after the start, with no history change.
REQ-026 num_stages SHALL be sampled at the start pulse only.
REQ-027 audio_out SHALL load the stored result on lrclk_posedge and otherwise hold.
- If o_done and lrclk_posedge coincide, audio_out SHALL take the new result.
REQ-028 A lrclk_negedge while o_busy=1 SHALL be dropped: pulse o_overrun, no change to the current computation.
REQ-029 cfg writes SHALL go to the pending bank at any time and never affect a computation in progress.
- A write coinciding with the start pulse SHALL be included in the copied bank.
REQ-030 Writes with cfg_stage >= MAX_STAGES or cfg_sel > 4 SHALL be ignored.
REQ-031 Deasserting i_valid mid-computation SHALL NOT abort the computation.
REQ-032 o_busy SHALL be high in MAC and WB only.

Reset
REQ-033 While i_rst_n=0, the block SHALL asynchronously force state IDLE and zero audio_out, result, o_busy, o_done, o_overrun, all stage histories and both coefficient banks.
REQ-034 Reset asserted mid-computation SHALL abandon it with no o_done; the first start after release SHALL begin from zero history.

Verification
REQ-035 Reset: assert i_rst_n=0 mid-MAC -> all outputs 0 immediately; no o_done after release until a new start.
REQ-036 Passthrough: 1 stage, b1=65536, others 0, x_in=1000 -> o_done 6 cycles after start; audio_out=1000 after next lrclk_posedge.
REQ-037 Bandpass impulse: 1 stage, b1=67, b2=0, b3=-67, a2=130709, a3=-65400; x_in=1000 then 0.
- First output = 1 (y=8).
- Following outputs match a bit-exact reference model for 3200 samples.
REQ-038 Saturation: 1 stage, b1=131071, x_in=30000 -> audio_out=32767; with x_in=-30000 -> audio_out=-32768.
REQ-039 Overrun: 4 stages, second lrclk_negedge 10 cycles after the first -> o_overrun pulse; first result still delivered at cycle 24; histories advanced once.
REQ-040 Shadow bank: write b1=0 during MAC of a 1-stage passthrough -> current output 1000; next sample output 0.
